// File: rtl/imu_seq_pkg.sv
// Shared types and constants for the IMU sample sequencer and its SPI frame shifter.
package imu_seq_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, PUBLISH} state_e;
  typedef enum logic [1:0] {F_ACCEL1, F_ACCEL2, F_GYRO} frame_e;

  localparam int   FRAME_BITS = 24;
  localparam int   CMD_BITS   = 8;
  localparam int   DATA_BITS  = FRAME_BITS - CMD_BITS;
  localparam int   OUT_BITS   = 10;
  localparam logic READ_BIT   = 1'b1;

  function automatic logic [CMD_BITS-1:0] read_cmd(input logic [6:0] reg_addr);
    return {READ_BIT, reg_addr};
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Purpose: one 24-bit SPI mode-3 frame (command byte out, 16 data bits in).
// Latency: 48*CLK_DIV cycles from start to done; done is a 1-cycle combinational strobe.
// Backpressure: none; start is only honoured while idle by the caller.
module spi_frame_shifter
  import imu_seq_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CMD_BITS-1:0]  cmd,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 mosi,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);

  logic                active;
  logic                high;
  logic [DW-1:0]       div;
  logic [BW-1:0]       bit_cnt;
  logic [CMD_BITS-1:0] tx;
  logic                half_end;

  assign half_end = active && (div == DW'(CLK_DIV - 1));
  assign done     = half_end && high && (bit_cnt == BW'(FRAME_BITS - 1));

  // tx empties to zero after the command byte, so the data phase drives mosi=0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      high    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      data    <= '0;
    end else if (start) begin
      active  <= 1'b1;
      high    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= cmd[CMD_BITS-1];
      tx      <= {cmd[CMD_BITS-2:0], 1'b0};
    end else if (active) begin
      if (!half_end) begin
        div <= div + 1'b1;
      end else begin
        div <= '0;
        if (!high) begin
          high <= 1'b1;
          sclk <= 1'b1;
          data <= {data[DATA_BITS-2:0], miso};
        end else if (done) begin
          active <= 1'b0;
          high   <= 1'b0;
        end else begin
          high    <= 1'b0;
          sclk    <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
          mosi    <= tx[CMD_BITS-1];
          tx      <= {tx[CMD_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/imu_sample_sequencer.sv
// Purpose: periodic 3-register SPI IMU poll, truncates to 10 bits and publishes atomically.
// Latency: 3*(50*CLK_DIV+CS_GAP) cycles from accepted tick to data_ready rising.
// Backpressure: none; ticks arriving while busy are dropped and counted in overrun_count.
module imu_sample_sequencer
  import imu_seq_pkg::*;
#(
  parameter int         CLK_DIV       = 4,
  parameter int         SAMPLE_PERIOD = 100000,
  parameter int         CS_GAP        = 4,
  parameter int         DR_PULSE      = 4,
  parameter logic [7:0] ADDR_ACCEL1   = 8'h3B,
  parameter logic [7:0] ADDR_ACCEL2   = 8'h3F,
  parameter logic [7:0] ADDR_GYRO     = 8'h43
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                spi_sclk,
  output logic                spi_cs_n,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [OUT_BITS-1:0] accel1,
  output logic [OUT_BITS-1:0] accel2,
  output logic [OUT_BITS-1:0] gyro,
  output logic                data_ready,
  output logic                busy,
  output logic [7:0]          overrun_count
);

  localparam int TW   = $clog2(SAMPLE_PERIOD);
  localparam int PMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int RW   = $clog2(DR_PULSE) + 1;

  state_e               state, state_nxt;
  frame_e               frame, frame_nxt;
  logic [PW-1:0]        ph_cnt, ph_cnt_nxt;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 sh_start, sh_done, capture, publish;
  logic [CMD_BITS-1:0]  sh_cmd;
  logic [DATA_BITS-1:0] sh_data;
  logic [OUT_BITS-1:0]  hold_a1, hold_a2, hold_gy;
  logic [RW-1:0]        dr_left;
  logic                 unused_sh_lsbs;

  assign tick           = enable && (tick_cnt == TW'(SAMPLE_PERIOD - 1));
  assign busy           = (state != IDLE);
  // truncation discards the low data bits
  assign unused_sh_lsbs = ^sh_data[DATA_BITS-OUT_BITS-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_comb begin
    sh_cmd = read_cmd(ADDR_GYRO[6:0]);
    case (frame)
      F_ACCEL1: sh_cmd = read_cmd(ADDR_ACCEL1[6:0]);
      F_ACCEL2: sh_cmd = read_cmd(ADDR_ACCEL2[6:0]);
      default:  sh_cmd = read_cmd(ADDR_GYRO[6:0]);
    endcase
  end

  spi_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (sh_start),
    .cmd     (sh_cmd),
    .miso    (spi_miso),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .done    (sh_done),
    .data    (sh_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      frame  <= F_ACCEL1;
      ph_cnt <= '0;
    end else begin
      state  <= state_nxt;
      frame  <= frame_nxt;
      ph_cnt <= ph_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_nxt  = frame;
    ph_cnt_nxt = ph_cnt;
    sh_start   = 1'b0;
    capture    = 1'b0;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt  = SETUP;
          frame_nxt  = F_ACCEL1;
          ph_cnt_nxt = '0;
        end
      end
      SETUP: begin
        if (ph_cnt == PW'(CLK_DIV - 1)) begin
          sh_start   = 1'b1;
          state_nxt  = SHIFT;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (sh_done) begin
          capture    = 1'b1;
          state_nxt  = HOLD;
          ph_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (ph_cnt == PW'(CLK_DIV - 1)) begin
          state_nxt  = GAP;
          ph_cnt_nxt = '0;
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      GAP: begin
        if (ph_cnt == PW'(CS_GAP - 1)) begin
          ph_cnt_nxt = '0;
          if (frame == F_GYRO) begin
            publish   = 1'b1;
            state_nxt = PUBLISH;
          end else begin
            frame_nxt = frame_e'(frame + 2'd1);
            state_nxt = SETUP;
          end
        end else begin
          ph_cnt_nxt = ph_cnt + 1'b1;
        end
      end
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cs_n registered from the next state so it is glitch-free and aligned with SETUP..HOLD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_cs_n      <= 1'b1;
      hold_a1       <= '0;
      hold_a2       <= '0;
      hold_gy       <= '0;
      accel1        <= '0;
      accel2        <= '0;
      gyro          <= '0;
      data_ready    <= 1'b0;
      dr_left       <= '0;
      overrun_count <= '0;
    end else begin
      spi_cs_n <= !(state_nxt == SETUP || state_nxt == SHIFT || state_nxt == HOLD);
      if (capture) begin
        case (frame)
          F_ACCEL1: hold_a1 <= sh_data[DATA_BITS-1 -: OUT_BITS];
          F_ACCEL2: hold_a2 <= sh_data[DATA_BITS-1 -: OUT_BITS];
          default:  hold_gy <= sh_data[DATA_BITS-1 -: OUT_BITS];
        endcase
      end
      if (publish) begin
        accel1     <= hold_a1;
        accel2     <= hold_a2;
        gyro       <= hold_gy;
        data_ready <= 1'b1;
        dr_left    <= RW'(DR_PULSE - 1);
      end else if (dr_left != '0) begin
        dr_left <= dr_left - 1'b1;
      end else begin
        data_ready <= 1'b0;
      end
      if (tick && busy && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imu_sample_sequencer.sv
// Directed bench for imu_sample_sequencer with a behavioural mode-3 IMU slave and frame monitor.
module tb_imu_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, enable;
  logic       spi_miso = 1'b0;
  logic       spi_sclk, spi_cs_n, spi_mosi;
  logic [9:0] accel1, accel2, gyro;
  logic       data_ready, busy;
  logic [7:0] overrun_count;

  logic       reset_o, enable_o;
  logic       miso_o = 1'b0;
  logic       o_sclk_unused, o_cs_n_unused, o_mosi_unused, o_busy_unused;
  logic [9:0] o_a1_unused, o_a2_unused, o_gy_unused;
  logic       data_ready_o;
  logic [7:0] overrun_o;

  imu_sample_sequencer #(.SAMPLE_PERIOD(1000)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .accel1(accel1), .accel2(accel2), .gyro(gyro),
    .data_ready(data_ready), .busy(busy), .overrun_count(overrun_count)
  );

  imu_sample_sequencer #(.SAMPLE_PERIOD(20)) dut_o (
    .clk(clk), .reset_n(reset_o), .enable(enable_o),
    .spi_sclk(o_sclk_unused), .spi_cs_n(o_cs_n_unused), .spi_mosi(o_mosi_unused), .spi_miso(miso_o),
    .accel1(o_a1_unused), .accel2(o_a2_unused), .gyro(o_gy_unused),
    .data_ready(data_ready_o), .busy(o_busy_unused), .overrun_count(overrun_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // IMU slave + monitor: answers by decoded register address, records each cs_n window
  logic [15:0] r1, r2, rg;
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  int          cnt_r = 0, cnt_f = 0;
  logic [7:0]  rx = '0;
  logic        dnz = 1'b0;
  logic [15:0] wsel;
  int          wn = 0;
  int          win_edges [64];
  logic [7:0]  win_cmd [64];
  logic        win_dnz [64];
  logic [7:0]  exp_cmd [3] = '{8'hBB, 8'hBF, 8'hC3};

  function automatic logic [15:0] resp(input logic [7:0] c);
    case (c)
      8'hBB:   return r1;
      8'hBF:   return r2;
      8'hC3:   return rg;
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    if (spi_cs_n) begin
      if (!prev_cs) begin
        win_edges[wn % 64] = cnt_r;
        win_cmd[wn % 64]   = rx;
        win_dnz[wn % 64]   = dnz;
        wn++;
      end
      cnt_r = 0; cnt_f = 0; rx = '0; dnz = 1'b0; spi_miso = 1'b0;
    end else begin
      if (spi_sclk && !prev_sclk) begin
        if (cnt_r < 8) rx = {rx[6:0], spi_mosi};
        else if (spi_mosi) dnz = 1'b1;
        cnt_r++;
      end
      if (!spi_sclk && prev_sclk) begin
        if (cnt_f >= 8 && cnt_f < 24) begin
          wsel = resp(rx);
          spi_miso = wsel[23 - cnt_f];
        end else begin
          spi_miso = 1'b0;
        end
        cnt_f++;
      end
    end
    prev_cs   = spi_cs_n;
    prev_sclk = spi_sclk;
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_sclk"}, 32'(spi_sclk), 1);
    chk({pfx, "_cs_n"}, 32'(spi_cs_n), 1);
    chk({pfx, "_mosi"}, 32'(spi_mosi), 0);
    chk({pfx, "_accel1"}, 32'(accel1), 0);
    chk({pfx, "_accel2"}, 32'(accel2), 0);
    chk({pfx, "_gyro"}, 32'(gyro), 0);
    chk({pfx, "_data_ready"}, 32'(data_ready), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_overrun"}, 32'(overrun_count), 0);
  endtask

  initial begin
    int n, fb, w, wn0, sd, nz, sb, wr;
    logic [7:0] po;
    reset_n = 1'b0; enable = 1'b0; reset_o = 1'b0; enable_o = 1'b0;
    r1 = 16'h1234; r2 = 16'hFFC0; rg = 16'h8000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("init");

    // single set: tick on edge 1000 after enable, data_ready on edge 1612
    wn0 = wn; reset_n = 1'b1; enable = 1'b1;
    n = 0; fb = -1;
    do begin
      @(posedge clk); #1; n++;
      if (busy && fb < 0) fb = n;
    end while (!data_ready && n < 3000);
    chk("set1_latency", n, 1612);
    chk("set1_busy_start", fb, 1000);
    chk("set1_accel1", 32'(accel1), 32'h048);
    chk("set1_accel2", 32'(accel2), 32'h3FF);
    chk("set1_gyro", 32'(gyro), 32'h200);
    chk("set1_busy_publish", 32'(busy), 1);
    @(posedge clk); #1;
    chk("set1_busy_end", 32'(busy), 0);
    w = 1;
    while (data_ready && w < 20) begin w++; @(posedge clk); #1; end
    chk("set1_dr_width", w, 4);
    chk("set1_windows", wn - wn0, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frame%0d_sclk_rises", i), win_edges[(wn0 + i) % 64], 24);
      chk($sformatf("frame%0d_cmd", i), 32'(win_cmd[(wn0 + i) % 64]), 32'(exp_cmd[i]));
      chk($sformatf("frame%0d_data_mosi", i), 32'(win_dnz[(wn0 + i) % 64]), 0);
    end

    // async reset during the next set's first command bit
    repeat (390) @(posedge clk);
    #1;
    chk("pre_rst_cs_n", 32'(spi_cs_n), 0);
    chk("pre_rst_sclk", 32'(spi_sclk), 0);
    chk("pre_rst_mosi", 32'(spi_mosi), 1);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("async");

    // reset in frame 2 of a set, with nothing published yet
    repeat (3) @(posedge clk);
    #1;
    r1 = 16'h7FFF; r2 = 16'h0040; rg = 16'hABCD;
    wn0 = wn; reset_n = 1'b1; sd = 0;
    for (int i = 0; i < 1300; i++) begin
      @(posedge clk); #1;
      if (data_ready) sd = 1;
    end
    chk("abort_busy", 32'(busy), 1);
    chk("abort_in_frame2", wn - wn0, 1);
    chk("abort_cs_n", 32'(spi_cs_n), 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_dr", sd, 0);
    chk("abort_accel1", 32'(accel1), 0);
    chk("abort_accel2", 32'(accel2), 0);
    chk("abort_gyro", 32'(gyro), 0);
    reset_n = 1'b1;
    n = 0; nz = 0;
    do begin
      @(posedge clk); #1; n++;
      if (!data_ready && (accel1 != 0 || accel2 != 0 || gyro != 0)) nz = 1;
    end while (!data_ready && n < 3000);
    chk("set2_latency", n, 1612);
    chk("set2_no_early_out", nz, 0);
    chk("set2_accel1", 32'(accel1), 32'h1FF);
    chk("set2_accel2", 32'(accel2), 32'h001);
    chk("set2_gyro", 32'(gyro), 32'h2AF);
    chk("set2_overrun", 32'(overrun_count), 0);

    // enable dropped during frame 1: set still completes, then silence
    reset_n = 1'b0;
    r1 = 16'h8040; r2 = 16'h003F; rg = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    repeat (1100) begin @(posedge clk); #1; n++; end
    enable = 1'b0;
    chk("endrop_busy", 32'(busy), 1);
    do begin
      @(posedge clk); #1; n++;
    end while (!data_ready && n < 3000);
    chk("endrop_latency", n, 1612);
    chk("endrop_accel1", 32'(accel1), 32'h201);
    chk("endrop_accel2", 32'(accel2), 32'h000);
    chk("endrop_gyro", 32'(gyro), 32'h3FF);
    @(posedge clk); #1;
    wn0 = wn; sb = 0;
    repeat (2500) begin
      @(posedge clk); #1;
      if (busy || !spi_cs_n) sb = 1;
    end
    chk("endrop_no_activity", sb, 0);
    chk("endrop_no_windows", wn - wn0, 0);

    // overrun on a 20-cycle tick period: 30 drops per set, saturating at 255
    reset_o = 1'b1; enable_o = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!data_ready_o && n < 2000);
    chk("ovr_latency", n, 632);
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_one_set", 32'(overrun_o), 30);
    wr = 0; po = overrun_o;
    repeat (6500) begin
      @(posedge clk); #1;
      if (overrun_o < po) wr = 1;
      po = overrun_o;
    end
    chk("ovr_saturated", 32'(overrun_o), 255);
    chk("ovr_no_wrap", wr, 0);
    chk("main_overrun_idle", 32'(overrun_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
